// File: rtl/fp_align_unit.sv
// Exponent alignment front end for the binary64 add/subtract datapath.
// Optional special-operand detection is enabled by defining FP_SPECIAL_DETECT_EN.
module fp_align_unit #(
    parameter int SHIFT_STEP = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        load,
    input  logic [63:0] a_in,
    input  logic [63:0] b_in,
    input  logic        op_sub,
    output logic [52:0] sig_a,
    output logic [52:0] sig_b,
    output logic        sign_a,
    output logic        sign_b,
    output logic        op_sub_out,
    output logic [10:0] exp_out,
    output logic        guard,
    output logic        sticky,
    output logic        is_nan,
    output logic        is_inf,
    output logic        busy,
    output logic        ready
);

    typedef enum logic [1:0] {IDLE, UNPACK, SHIFT, DONE} state_t;

    state_t      state_reg, state_next;
    logic [63:0] a_reg, a_next, b_reg, b_next;
    logic        op_reg, op_next;
    logic [52:0] sig_a_reg, sig_a_next, sig_b_reg, sig_b_next;
    logic        sign_a_reg, sign_a_next, sign_b_reg, sign_b_next;
    logic [10:0] exp_reg, exp_next;
    logic        guard_reg, guard_next, sticky_reg, sticky_next;
    logic        nan_reg, nan_next, inf_reg, inf_next;
    logic        tgt_b_reg, tgt_b_next;
    logic [5:0]  rem_reg, rem_next;

    // Unpacked view of the captured operands
    logic [10:0] eff_a, eff_b, diff;
    logic [52:0] sig_a_unp, sig_b_unp;
    logic        b_target;

    assign eff_a     = (a_reg[62:52] == 11'd0) ? 11'd1 : a_reg[62:52];
    assign eff_b     = (b_reg[62:52] == 11'd0) ? 11'd1 : b_reg[62:52];
    assign sig_a_unp = {a_reg[62:52] != 11'd0, a_reg[51:0]};
    assign sig_b_unp = {b_reg[62:52] != 11'd0, b_reg[51:0]};
    assign b_target  = (eff_a >= eff_b);
    assign diff      = b_target ? (eff_a - eff_b) : (eff_b - eff_a);

    logic nan_hit, inf_hit;
`ifdef FP_SPECIAL_DETECT_EN
    logic a_max, b_max, a_inf, b_inf;
    assign a_max   = (a_reg[62:52] == 11'h7FF);
    assign b_max   = (b_reg[62:52] == 11'h7FF);
    assign a_inf   = a_max && (a_reg[51:0] == 52'd0);
    assign b_inf   = b_max && (b_reg[51:0] == 52'd0);
    // inf - inf (after folding the signs into the op) has no defined result
    assign nan_hit = (a_max && !a_inf) || (b_max && !b_inf) ||
                     (a_inf && b_inf && (op_reg ^ a_reg[63] ^ b_reg[63]));
    assign inf_hit = a_inf || b_inf;
`else
    assign nan_hit = 1'b0;
    assign inf_hit = 1'b0;
`endif

    // One iterative shift step on the target significand
    logic [5:0]  k;
    logic [52:0] tgt, shifted, guard_vec, low_mask;
    assign k         = (rem_reg < 6'(SHIFT_STEP)) ? rem_reg : 6'(SHIFT_STEP);
    assign tgt       = tgt_b_reg ? sig_b_reg : sig_a_reg;
    assign shifted   = tgt >> k;
    assign guard_vec = tgt >> (k - 6'd1);
    assign low_mask  = (53'd1 << (k - 6'd1)) - 53'd1;

    always_comb begin
        state_next  = state_reg;
        a_next      = a_reg;
        b_next      = b_reg;
        op_next     = op_reg;
        sig_a_next  = sig_a_reg;
        sig_b_next  = sig_b_reg;
        sign_a_next = sign_a_reg;
        sign_b_next = sign_b_reg;
        exp_next    = exp_reg;
        guard_next  = guard_reg;
        sticky_next = sticky_reg;
        nan_next    = nan_reg;
        inf_next    = inf_reg;
        tgt_b_next  = tgt_b_reg;
        rem_next    = rem_reg;
        if (load) begin
            a_next      = a_in;
            b_next      = b_in;
            op_next     = op_sub;
            guard_next  = 1'b0;
            sticky_next = 1'b0;
            nan_next    = 1'b0;
            inf_next    = 1'b0;
            state_next  = UNPACK;
        end else begin
            case (state_reg)
                UNPACK: begin
                    sig_a_next  = sig_a_unp;
                    sig_b_next  = sig_b_unp;
                    sign_a_next = a_reg[63];
                    sign_b_next = b_reg[63];
                    exp_next    = b_target ? eff_a : eff_b;
                    tgt_b_next  = b_target;
                    if (nan_hit || inf_hit) begin
                        nan_next   = nan_hit;
                        inf_next   = inf_hit;
                        exp_next   = 11'h7FF;
                        state_next = DONE;
                    end else if (diff == 11'd0) begin
                        state_next = DONE;
                    end else if (diff >= 11'd54) begin
                        if (b_target) begin
                            sig_b_next  = 53'd0;
                            sticky_next = |sig_b_unp;
                        end else begin
                            sig_a_next  = 53'd0;
                            sticky_next = |sig_a_unp;
                        end
                        guard_next = 1'b0;
                        state_next = DONE;
                    end else begin
                        rem_next   = diff[5:0];
                        state_next = SHIFT;
                    end
                end
                SHIFT: begin
                    if (tgt_b_reg) sig_b_next = shifted;
                    else           sig_a_next = shifted;
                    guard_next  = guard_vec[0];
                    sticky_next = sticky_reg | guard_reg | (|(tgt & low_mask));
                    rem_next    = rem_reg - k;
                    if (rem_reg == k) state_next = DONE;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            a_reg      <= '0;
            b_reg      <= '0;
            op_reg     <= 1'b0;
            sig_a_reg  <= '0;
            sig_b_reg  <= '0;
            sign_a_reg <= 1'b0;
            sign_b_reg <= 1'b0;
            exp_reg    <= '0;
            guard_reg  <= 1'b0;
            sticky_reg <= 1'b0;
            nan_reg    <= 1'b0;
            inf_reg    <= 1'b0;
            tgt_b_reg  <= 1'b0;
            rem_reg    <= '0;
        end else if (en) begin
            state_reg  <= state_next;
            a_reg      <= a_next;
            b_reg      <= b_next;
            op_reg     <= op_next;
            sig_a_reg  <= sig_a_next;
            sig_b_reg  <= sig_b_next;
            sign_a_reg <= sign_a_next;
            sign_b_reg <= sign_b_next;
            exp_reg    <= exp_next;
            guard_reg  <= guard_next;
            sticky_reg <= sticky_next;
            nan_reg    <= nan_next;
            inf_reg    <= inf_next;
            tgt_b_reg  <= tgt_b_next;
            rem_reg    <= rem_next;
        end
    end

    assign sig_a      = sig_a_reg;
    assign sig_b      = sig_b_reg;
    assign sign_a     = sign_a_reg;
    assign sign_b     = sign_b_reg;
    assign op_sub_out = op_reg;
    assign exp_out    = exp_reg;
    assign guard      = guard_reg;
    assign sticky     = sticky_reg;
    assign is_nan     = nan_reg;
    assign is_inf     = inf_reg;
    assign busy       = (state_reg == UNPACK) || (state_reg == SHIFT);
    assign ready      = (state_reg == DONE);

endmodule

// File: doc/fp_align_unit.md
Name: fp_align_unit

Overview:
- Front-end stage of the double-precision add/subtract datapath. It sits directly upstream of the 53-bit significand adder/subtractor.
- Unpacks two IEEE-754 binary64 operands and selects the larger exponent as the common exponent.
- Iteratively right-shifts the significand with the smaller exponent, accumulating guard/sticky bits.
- Presents aligned 53-bit significands, signs and the add/subtract op with a load/ready handshake matching the adder's.

Parameters:
SHIFT_STEP, 8, maximum right-shift distance applied per SHIFT cycle (1..55)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous reset, active-high
en  input  1  clock enable; 0 freezes all state and outputs
load  input  1  capture a_in/b_in/op_sub (only when en=1)
a_in  input  64  operand A, binary64
b_in  input  64  operand B, binary64
op_sub  input  1  0=add, 1=subtract; forwarded unchanged
sig_a  output  53  aligned significand A {hidden,frac}
sig_b  output  53  aligned significand B
sign_a  output  1  sign of A
sign_b  output  1  sign of B
op_sub_out  output  1  registered op_sub
exp_out  output  11  common (larger effective) exponent
guard  output  1  last bit shifted out of the smaller operand
sticky  output  1  OR of all bits shifted out below guard
is_nan  output  1  see Optional Feature
is_inf  output  1  see Optional Feature
busy  output  1  high in UNPACK or SHIFT
ready  output  1  high in DONE; outputs valid

Behaviour:
- Reset: synchronous, active-high, highest priority. All outputs and internal registers go to 0; state IDLE.
- States: IDLE, UNPACK, SHIFT, DONE.
- Enable: en=0 holds state, counters and outputs; load is ignored.
- Load: en=1 and load=1 in any state:
  - Registers operands and op_sub; clears ready, guard and sticky; next state UNPACK.
  - Load during UNPACK/SHIFT aborts the in-flight alignment; the new operands win.
- UNPACK (one cycle):
  - Per operand: hidden = (exp!=0); effective exponent = exp==0 ? 1 : exp.
  - exp_out = max(effA, effB); d = |effA - effB|. The operand with the smaller exponent is the shift target; operand positions are never swapped.
  - d=0: next state DONE.
  - d>=54: target significand <= 0, guard <= 0, sticky <= OR(target significand); next state DONE.
  - Otherwise: remaining <= d; next state SHIFT.
- SHIFT:
  - Each cycle shifts the target right by k = min(remaining, SHIFT_STEP); remaining -= k.
  - New guard = bit k-1 of the pre-shift value. sticky |= old guard | OR(bits k-2..0).
  - Reaching remaining=0 moves to DONE.
- Latency: ready rises on the edge after 1 + ceil(d/SHIFT_STEP) edges past the load edge. d=0 or d>=54: 1 edge.
- DONE: ready=1, busy=0. Outputs hold until the next load or rst. The downstream adder samples on ready and issues its own load.
- IDLE: ready=0, busy=0; outputs keep last values (0 after reset).
- Exponent 2047 without the optional feature is treated as a normal exponent.

Optional Feature:
- Macro: FP_SPECIAL_DETECT_EN.
- Defined:
  - In UNPACK, exponent 2047 with frac!=0 on either operand sets is_nan=1.
  - Exponent 2047 with frac=0 sets is_inf=1.
  - Also is_nan=1 for +inf combined with -inf under effective subtraction, where effective-sub = op_sub XOR sign_a XOR sign_b.
  - Either flag skips SHIFT and goes to DONE; significands are passed unshifted and exp_out=2047.
  - Flags clear on load/rst.
- Undefined: is_nan and is_inf tied 0; no special-case path.

Test Plan:
- a=0x3FF0000000000000, b=0x3FF0000000000000, op_sub=0 -> 1 edge after load: ready=1, sig_a=sig_b=0x10000000000000, exp_out=0x3FF, guard=0, sticky=0.
- a=0x3FF0000000000000, b=0x3FE0000000000000 (SHIFT_STEP=8) -> ready after 2 edges: sig_b=0x08000000000000, exp_out=0x3FF, guard=0, sticky=0.
- a=0x4130000000000000 (2^20), b=0x3FF0000000000001 -> d=20, 3 SHIFT cycles, ready after 4 edges: sig_b=0x0000000100000000, guard=0, sticky=1, sig_a=0x10000000000000, exp_out=0x413.
- a=0x43F0000000000000 (2^64), b=0x3FF0000000000000 -> d=64: ready after 1 edge, sig_b=0, guard=0, sticky=1.
- Start the 2^20 case; assert load with equal 1.0 operands in the 2nd SHIFT cycle -> 1 edge later ready=1 with the 1.0/1.0 result. Repeat with rst instead -> all outputs 0, state IDLE. Repeat holding en=0 for 5 cycles mid-SHIFT -> the final result is unchanged, arriving 5 cycles later.
- With FP_SPECIAL_DETECT_EN: a=0x7FF0000000000000, b=0xFFF0000000000000, op_sub=0 -> is_nan=1, exp_out=0x7FF, ready after 1 edge. Without the macro the same stimulus -> is_nan=is_inf=0.
